// File: rtl/dm_access_arbiter.sv
// -----------------------------------------------------------------------------
// dm_access_arbiter
//   Shares the single data memory between the MEM pipeline stage (CPU port,
//   default priority) and a secondary bus master (DMA port). One access is in
//   flight at a time; it is sequenced IDLE -> ISSUE -> (WAIT) -> DONE.
//
// Parameters
//   MEM_LATENCY   cycles from the mem_en cycle to the edge at which mem_rdata
//                 is captured (1..4)
//   STARVE_LIMIT  max consecutive CPU grants while dma_req is pending (1..15)
//
// Ports
//   clk, reset             rising-edge clock, async active-low reset
//   cpu_* / dma_*          request bundles (req, we, be, addr, wdata) in;
//                          rdata + one-cycle done pulse out per port
//   cpu_stall              cpu_req & ~cpu_done, gated low while in reset
//   mem_*                  memory strobe/write/byte-enable/address/data out,
//                          mem_rdata in
//   busy                   an access is in progress (state != IDLE)
// -----------------------------------------------------------------------------
module dm_access_arbiter #(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_be,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [3:0]  dma_be,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_done,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  localparam logic [1:0] WAIT_INIT  = 2'(MEM_LATENCY - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_e      state_q,      state_d;
  logic [1:0]  wait_cnt_q,   wait_cnt_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        owner_dma_q,  owner_dma_d;
  logic        mem_en_q,     mem_en_d;
  logic        mem_we_q,     mem_we_d;
  logic [3:0]  mem_be_q,     mem_be_d;
  logic [31:0] mem_addr_q,   mem_addr_d;
  logic [31:0] mem_wdata_q,  mem_wdata_d;
  logic [31:0] cpu_rdata_q,  cpu_rdata_d;
  logic [31:0] dma_rdata_q,  dma_rdata_d;
  logic        cpu_done_q,   cpu_done_d;
  logic        dma_done_q,   dma_done_d;

  logic        grant_dma;
  logic        finish;   // access completes at the coming edge -> DONE

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // statement leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    starve_cnt_d = starve_cnt_q;
    owner_dma_d  = owner_dma_q;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    cpu_done_d   = 1'b0;
    dma_done_d   = 1'b0;
    grant_dma    = 1'b0;
    finish       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!dma_req) starve_cnt_d = '0;
        if (cpu_req || dma_req) begin
          // CPU has priority unless DMA has waited through STARVE_LIMIT grants.
          grant_dma   = dma_req && (!cpu_req || starve_cnt_q == STARVE_MAX);
          owner_dma_d = grant_dma;
          mem_we_d    = grant_dma ? dma_we    : cpu_we;
          mem_be_d    = grant_dma ? dma_be    : cpu_be;
          mem_addr_d  = grant_dma ? dma_addr  : cpu_addr;
          mem_wdata_d = grant_dma ? dma_wdata : cpu_wdata;
          mem_en_d    = 1'b1;
          state_d     = ISSUE;
          if (grant_dma) begin
            starve_cnt_d = '0;
          end else if (dma_req && starve_cnt_q != STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end
      end
      ISSUE: begin
        if (mem_we_q || MEM_LATENCY == 1) begin
          finish = 1'b1;
        end else begin
          wait_cnt_d = WAIT_INIT;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - 2'd1;
        if (wait_cnt_q == 2'd1) finish = 1'b1;
      end
      default: state_d = IDLE;   // DONE: no arbitration in this cycle
    endcase

    if (finish) begin
      state_d    = DONE;
      cpu_done_d = !owner_dma_q;
      dma_done_d = owner_dma_q;
      // Writes leave the granted port's rdata at its previous value.
      if (!mem_we_q) begin
        if (owner_dma_q) dma_rdata_d = mem_rdata;
        else             cpu_rdata_d = mem_rdata;
      end
    end
  end

  // NOTE: every flop here is a control or output register, so all of them are
  // reset; an access in flight at reset is simply dropped without a done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      starve_cnt_q <= '0;
      owner_dma_q  <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      cpu_done_q   <= 1'b0;
      dma_done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // present before the edge, independent of statement order.
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      owner_dma_q  <= owner_dma_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      cpu_done_q   <= cpu_done_d;
      dma_done_q   <= dma_done_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign cpu_done  = cpu_done_q;
  assign dma_done  = dma_done_q;
  assign busy      = (state_q != IDLE);
  // Gated by reset so that every output reads 0 while reset is asserted.
  assign cpu_stall = reset & cpu_req & ~cpu_done_q;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_access_arbiter
//   Two arbiter instances: dut0 (MEM_LATENCY=1, STARVE_LIMIT=2) and
//   dut1 (MEM_LATENCY=3, STARVE_LIMIT=4), each with its own behavioural memory.
//   A transaction-level reference model predicts, per cycle, the issue cycle,
//   done cycle, winner and read data of each access from the arbitration rules.
// -----------------------------------------------------------------------------
module tb_dm_access_arbiter;

  localparam int L0 = 1, S0 = 2;
  localparam int L1 = 3, S1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n   [2];
  logic        cpu_req   [2];
  logic        cpu_we    [2];
  logic [3:0]  cpu_be    [2];
  logic [31:0] cpu_addr  [2];
  logic [31:0] cpu_wdata [2];
  logic [31:0] cpu_rdata [2];
  logic        cpu_done  [2];
  logic        cpu_stall [2];
  logic        dma_req   [2];
  logic        dma_we    [2];
  logic [3:0]  dma_be    [2];
  logic [31:0] dma_addr  [2];
  logic [31:0] dma_wdata [2];
  logic [31:0] dma_rdata [2];
  logic        dma_done  [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [3:0]  mem_be    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        busy      [2];

  dm_access_arbiter #(.MEM_LATENCY(L0), .STARVE_LIMIT(S0)) dut0 (
    .clk(clk), .reset(reset_n[0]),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_be(cpu_be[0]),
    .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]), .cpu_rdata(cpu_rdata[0]),
    .cpu_done(cpu_done[0]), .cpu_stall(cpu_stall[0]),
    .dma_req(dma_req[0]), .dma_we(dma_we[0]), .dma_be(dma_be[0]),
    .dma_addr(dma_addr[0]), .dma_wdata(dma_wdata[0]), .dma_rdata(dma_rdata[0]),
    .dma_done(dma_done[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_be(mem_be[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .busy(busy[0])
  );

  dm_access_arbiter #(.MEM_LATENCY(L1), .STARVE_LIMIT(S1)) dut1 (
    .clk(clk), .reset(reset_n[1]),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_be(cpu_be[1]),
    .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]), .cpu_rdata(cpu_rdata[1]),
    .cpu_done(cpu_done[1]), .cpu_stall(cpu_stall[1]),
    .dma_req(dma_req[1]), .dma_we(dma_we[1]), .dma_be(dma_be[1]),
    .dma_addr(dma_addr[1]), .dma_wdata(dma_wdata[1]), .dma_rdata(dma_rdata[1]),
    .dma_done(dma_done[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_be(mem_be[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .busy(busy[1])
  );

  function automatic logic [31:0] init_word(input int k, input int i);
    if (i == 4) return 32'hDEAD_BEEF;
    return 32'hA5C3_0000 + 32'(k * 256 + i * 17);
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? L0 : L1;
  endfunction

  function automatic int sl_of(input int k);
    return (k == 0) ? S0 : S1;
  endfunction

  // Behavioural memories: 16 words indexed by addr[5:2]. Read data for an
  // access issued in cycle c is presented during cycle c+LAT-1; any other
  // time the bus shows a poison value so a mistimed capture is visible.
  for (genvar k = 0; k < 2; k++) begin : g_env
    localparam int LAT  = (k == 0) ? L0 : L1;
    localparam int PIDX = (LAT > 1) ? LAT - 2 : 0;
    logic [31:0] mem  [16];
    logic [31:0] pipe [4];
    logic [31:0] rd_now;

    initial for (int i = 0; i < 16; i++) mem[i] <= init_word(k, i);

    assign rd_now = (mem_en[k] && !mem_we[k]) ? mem[mem_addr[k][5:2]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
      if (mem_en[k] && mem_we[k]) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[k][b]) mem[mem_addr[k][5:2]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
      end
      pipe[0] <= rd_now;
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end

    assign mem_rdata[k] = (LAT == 1) ? rd_now : pipe[PIDX];
  end

  // ---------------------------------------------------------------- model
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] ref_mem [2][16];
  int          m_cyc   [2];
  int          m_issue [2];
  int          m_done  [2];
  int          m_sc    [2];
  bit          m_active[2];
  bit          m_port  [2];   // 0 = CPU, 1 = DMA
  bit          m_we    [2];
  logic [3:0]  m_be    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rd    [2];
  logic [31:0] m_cpu_rd[2];
  logic [31:0] m_dma_rd[2];
  bit          m_cdone_seen[2];
  bit          m_ddone_seen[2];
  bit          log_en = 1'b0;
  int          grant_q[$];

  task automatic chk32(input int k, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL dut%0d %s cyc %0d: observed %h expected %h", k, tag, m_cyc[k], obs, exp);
    end
  endtask

  task automatic chk1(input int k, input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL dut%0d %s cyc %0d: observed %b expected %b", k, tag, m_cyc[k], obs, exp);
    end
  endtask

  // Called at posedge+1 with this cycle's inputs applied; checks at negedge,
  // advances the model, returns at the next posedge+1.
  task automatic step(input int k);
    bit e_en, e_cd, e_dd, win_dma;
    int w;
    @(negedge clk);
    if (!reset_n[k]) begin
      m_active[k] = 1'b0;
      m_sc[k]     = 0;
      m_cpu_rd[k] = '0;
      m_dma_rd[k] = '0;
    end
    e_en = m_active[k] && (m_cyc[k] == m_issue[k]);
    e_cd = m_active[k] && (m_cyc[k] == m_done[k]) && !m_port[k];
    e_dd = m_active[k] && (m_cyc[k] == m_done[k]) &&  m_port[k];
    if (e_cd && !m_we[k]) m_cpu_rd[k] = m_rd[k];
    if (e_dd && !m_we[k]) m_dma_rd[k] = m_rd[k];

    chk1 (k, "mem_en",    mem_en[k],    e_en);
    chk1 (k, "busy",      busy[k],      m_active[k]);
    chk1 (k, "cpu_done",  cpu_done[k],  e_cd);
    chk1 (k, "dma_done",  dma_done[k],  e_dd);
    chk1 (k, "cpu_stall", cpu_stall[k], reset_n[k] && cpu_req[k] && !e_cd);
    chk32(k, "cpu_rdata", cpu_rdata[k], m_cpu_rd[k]);
    chk32(k, "dma_rdata", dma_rdata[k], m_dma_rd[k]);
    if (e_en) begin
      chk1 (k, "mem_we",    mem_we[k],         m_we[k]);
      chk32(k, "mem_be",    32'(mem_be[k]),    32'(m_be[k]));
      chk32(k, "mem_addr",  mem_addr[k],       m_addr[k]);
      chk32(k, "mem_wdata", mem_wdata[k],      m_wdata[k]);
    end
    if (log_en) begin
      if (cpu_done[k]) grant_q.push_back(0);
      if (dma_done[k]) grant_q.push_back(1);
    end
    m_cdone_seen[k] = e_cd;
    m_ddone_seen[k] = e_dd;

    if (reset_n[k]) begin
      if (m_active[k]) begin
        if (m_cyc[k] == m_done[k]) m_active[k] = 1'b0;
      end else begin
        if (!dma_req[k]) m_sc[k] = 0;
        if (cpu_req[k] || dma_req[k]) begin
          win_dma = dma_req[k] && (!cpu_req[k] || m_sc[k] == sl_of(k));
          m_port[k] = win_dma;
          if (win_dma) begin
            m_we[k] = dma_we[k]; m_be[k] = dma_be[k];
            m_addr[k] = dma_addr[k]; m_wdata[k] = dma_wdata[k];
            m_sc[k] = 0;
          end else begin
            m_we[k] = cpu_we[k]; m_be[k] = cpu_be[k];
            m_addr[k] = cpu_addr[k]; m_wdata[k] = cpu_wdata[k];
            if (dma_req[k] && m_sc[k] < sl_of(k)) m_sc[k]++;
          end
          m_active[k] = 1'b1;
          m_issue[k]  = m_cyc[k] + 1;
          m_done[k]   = m_we[k] ? m_cyc[k] + 2 : m_cyc[k] + 1 + lat_of(k);
          w = int'(m_addr[k][5:2]);
          if (m_we[k]) begin
            for (int b = 0; b < 4; b++)
              if (m_be[k][b]) ref_mem[k][w][8*b +: 8] = m_wdata[k][8*b +: 8];
          end else begin
            m_rd[k] = ref_mem[k][w];
          end
        end
      end
    end
    m_cyc[k]++;
    @(posedge clk);
    #1;
  endtask

  // Steps one cycle, then withdraws any request whose done the model expected.
  task automatic step_release(input int k);
    step(k);
    if (m_cdone_seen[k]) cpu_req[k] = 1'b0;
    if (m_ddone_seen[k]) dma_req[k] = 1'b0;
  endtask

  task automatic set_port(input int k, input bit dma, input bit req, input bit we,
                          input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
    if (dma) begin
      dma_req[k] = req; dma_we[k] = we; dma_be[k] = be; dma_addr[k] = addr; dma_wdata[k] = wd;
    end else begin
      cpu_req[k] = req; cpu_we[k] = we; cpu_be[k] = be; cpu_addr[k] = addr; cpu_wdata[k] = wd;
    end
  endtask

  task automatic run_port(input int k, input bit dma, input bit we,
                          input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
    set_port(k, dma, 1'b1, we, be, addr, wd);
    for (int i = 0; i < 16; i++) begin
      step_release(k);
      if (dma ? !dma_req[k] : !cpu_req[k]) break;
    end
    set_port(k, dma, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(k);
  endtask

  task automatic drain(input int k);
    cpu_req[k] = 1'b0;
    dma_req[k] = 1'b0;
    for (int i = 0; i < 8; i++) step(k);
  endtask

  task automatic chk_zero(input int k);
    chk1 (k, "rst_mem_en",    mem_en[k],          1'b0);
    chk1 (k, "rst_mem_we",    mem_we[k],          1'b0);
    chk32(k, "rst_mem_be",    32'(mem_be[k]),     32'h0);
    chk32(k, "rst_mem_addr",  mem_addr[k],        32'h0);
    chk32(k, "rst_mem_wdata", mem_wdata[k],       32'h0);
    chk1 (k, "rst_busy",      busy[k],            1'b0);
    chk1 (k, "rst_cpu_done",  cpu_done[k],        1'b0);
    chk1 (k, "rst_dma_done",  dma_done[k],        1'b0);
    chk1 (k, "rst_cpu_stall", cpu_stall[k],       1'b0);
    chk32(k, "rst_cpu_rdata", cpu_rdata[k],       32'h0);
    chk32(k, "rst_dma_rdata", dma_rdata[k],       32'h0);
  endtask

  task automatic rand_drive(input int k);
    if (!cpu_req[k] || m_cdone_seen[k])
      set_port(k, 1'b0, $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
               4'($urandom), $urandom & 32'hFFFF_FFFC, $urandom);
    if (!dma_req[k] || m_ddone_seen[k])
      set_port(k, 1'b1, $urandom_range(0, 9) < 5, 1'($urandom_range(0, 1)),
               4'($urandom), $urandom & 32'hFFFF_FFFC, $urandom);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int exp_order [6] = '{0, 0, 1, 0, 0, 1};

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) ref_mem[k][i] = init_word(k, i);
      m_cyc[k] = 0; m_issue[k] = 0; m_done[k] = 0; m_sc[k] = 0;
      m_active[k] = 1'b0; m_port[k] = 1'b0; m_we[k] = 1'b0;
      m_be[k] = '0; m_addr[k] = '0; m_wdata[k] = '0; m_rd[k] = '0;
      m_cpu_rd[k] = '0; m_dma_rd[k] = '0;
      m_cdone_seen[k] = 1'b0; m_ddone_seen[k] = 1'b0;
      reset_n[k] = 1'b0;
      set_port(k, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      set_port(k, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    end

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk_zero(0);
    chk_zero(1);
    reset_n[0] = 1'b1;
    reset_n[1] = 1'b1;

    // dut0: CPU load from 0x10 returns 0xDEADBEEF two cycles after request.
    run_port(0, 1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
    chk32(0, "t1_cpu_rdata", cpu_rdata[0], 32'hDEAD_BEEF);

    // dut0: CPU half-word store, read back; then an all-zero-BE store.
    run_port(0, 1'b0, 1'b1, 4'b0011, 32'h0000_0024, 32'h0000_ABCD);
    run_port(0, 1'b0, 1'b0, 4'hF,    32'h0000_0024, 32'h0);
    chk32(0, "t2_merge", cpu_rdata[0], {init_word(0, 9) & 32'hFFFF_0000} | 32'h0000_ABCD);
    run_port(0, 1'b1, 1'b1, 4'b0000, 32'h0000_0008, 32'hFFFF_FFFF);
    run_port(0, 1'b1, 1'b0, 4'hF,    32'h0000_0008, 32'h0);
    chk32(0, "be0_unchanged", dma_rdata[0], init_word(0, 2));

    // dut0: both ports held continuously, STARVE_LIMIT=2.
    set_port(0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0030, 32'h0);
    set_port(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0034, 32'h0);
    grant_q.delete();
    log_en = 1'b1;
    for (int i = 0; i < 19; i++) step(0);
    log_en = 1'b0;
    drain(0);
    for (int i = 0; i < 6; i++)
      chk32(0, "grant_order", (i < grant_q.size()) ? 32'(grant_q[i]) : 32'hFFFF_FFFF,
            32'(exp_order[i]));

    // dut1 (latency 3): DMA load from 0x100.
    run_port(1, 1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0);
    chk32(1, "t3_dma_rdata", dma_rdata[1], init_word(1, 0));

    // dut1: CPU load in flight while DMA request arrives in its WAIT phase.
    set_port(1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0008, 32'h0);
    step_release(1);
    step_release(1);
    set_port(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0204, 32'h0);
    for (int i = 0; i < 12; i++) step_release(1);
    chk32(1, "t6_cpu_rdata", cpu_rdata[1], init_word(1, 2));
    chk32(1, "t6_dma_rdata", dma_rdata[1], init_word(1, 1));
    drain(1);

    // dut1: reset asserted mid-WAIT of a CPU read; request still pending.
    set_port(1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
    step(1);
    step(1);
    #2;
    reset_n[1] = 1'b0;
    #1;
    chk_zero(1);
    step(1);
    step(1);
    reset_n[1] = 1'b1;
    for (int i = 0; i < 8; i++) step_release(1);
    chk32(1, "t5_cpu_rdata", cpu_rdata[1], 32'hDEAD_BEEF);
    drain(1);

    // Randomized traffic on both instances.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 400; i++) begin
        rand_drive(k);
        step(k);
      end
      drain(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dm_access_arbiter.md
Name: dm_access_arbiter

Overview:
- Sequences and shares the single data memory between the MEM pipeline stage (CPU port, default priority) and a secondary bus master (DMA port).
- Drives the memory's enable, write, byte-enable, address and data inputs.
- Returns read data and a one-cycle done pulse to the granted requester.
- Stalls the pipeline while a CPU access is outstanding; bounded anti-starvation for DMA.

Parameters:
MEM_LATENCY, 1, cycles from issue (mem_en high) to valid mem_rdata; legal 1..4
STARVE_LIMIT, 4, max consecutive CPU grants while dma_req is pending; legal 1..15

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request; held until cpu_done
cpu_we  in  1  1 = store, 0 = load
cpu_be  in  4  byte enables (from BE decode)
cpu_addr  in  32  byte address
cpu_wdata  in  32  store data
cpu_rdata  out  32  load data, valid while cpu_done=1
cpu_done  out  1  one-cycle completion pulse
cpu_stall  out  1  cpu_req & ~cpu_done
dma_req, dma_we, dma_be[4], dma_addr[32], dma_wdata[32]  in  DMA request bundle, same rules as CPU
dma_rdata  out  32  load data, valid while dma_done=1
dma_done  out  1  one-cycle completion pulse
mem_en  out  1  memory access strobe
mem_we  out  1  memory write
mem_be  out  4  memory byte enables
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid MEM_LATENCY cycles after mem_en
busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE; wait counter=0; starve counter=0; grant owner=CPU. All outputs 0. Any in-flight access is abandoned with no done pulse. Release is synchronous to the next clk edge.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: arbitrate among the requests present. Register the winner's addr/be/we/wdata into mem_* holding registers; next state ISSUE. No request: stay in IDLE.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: CPU wins, unless starve counter == STARVE_LIMIT, in which case DMA wins.
- Starve counter:
  - +1 on each CPU grant made while dma_req=1; saturates at STARVE_LIMIT.
  - Cleared on any DMA grant, or in any IDLE cycle with dma_req=0.
- ISSUE (one cycle): mem_en=1; mem_we/be/addr/wdata from the holding registers.
  - Write: next state DONE.
  - Read with MEM_LATENCY=1: next state DONE, capturing mem_rdata at the ISSUE->DONE edge.
  - Read with MEM_LATENCY>1: next state WAIT with wait counter = MEM_LATENCY-1.
- WAIT: mem_en=0. Decrement the counter each cycle. On the final count, capture mem_rdata into the granted port's rdata register; next state DONE.
- DONE (one cycle):
  - Pulse the granted port's done; the other port's done stays 0.
  - rdata is held until the next capture for that port; it is undefined-but-stable for writes (the prior value is retained).
  - Next state: IDLE. No arbitration occurs in DONE.
- Latency, request first seen in IDLE at cycle T:
  - Read: mem_en at T+1, done at T+2+MEM_LATENCY-1.
  - Write: mem_en at T+1, done at T+2.
- cpu_stall is combinational: high from the cycle cpu_req rises through the cycle before cpu_done, including cycles lost to DMA arbitration.
- Requester rules:
  - A request bundle must stay stable from req rise until its done.
  - A new request may be presented in the cycle after done; re-arbitration happens in the IDLE state that follows.
- Simultaneous events:
  - req deasserted mid-access: the memory access still completes and done still pulses.
  - be=4'b0000 write: issued normally; memory contents unchanged.

Test Plan:
1. MEM_LATENCY=1, CPU load addr 0x10, memory returns 0xDEADBEEF; req rises at cycle 0 -> mem_en=1 in cycle 1 with mem_addr=0x10, mem_we=0; cpu_done=1 with cpu_rdata=0xDEADBEEF in cycle 2; cpu_stall=1 in cycles 0-1 and 0 in cycle 2.
2. CPU store addr 0x24, be=4'b0011, wdata 0x0000ABCD -> mem_en=mem_we=1, mem_be=0011 in cycle 1; cpu_done in cycle 2; dma_done stays 0.
3. MEM_LATENCY=3, DMA load addr 0x100 -> mem_en in cycle 1 only; dma_done with captured data in cycle 4; busy=1 in cycles 1-4.
4. STARVE_LIMIT=2, cpu_req and dma_req both held continuously -> grant order CPU, CPU, DMA, CPU, CPU, DMA.
5. reset driven low during WAIT of a CPU read -> all outputs 0 immediately without a clock edge; no cpu_done; after release, a pending req is issued normally.
6. CPU load in flight while dma_req rises -> DMA issued only after the DONE and IDLE cycles; cpu_stall unaffected by DMA activity.
